// File: rtl/adder_timing_sequencer.sv
// Measurement sequencer for the instrumented adder: holds operands, gates the ring/counter for a
// programmed window, waits for the count to settle, and returns count/sum over a valid/ready channel.
module adder_timing_sequencer #(
    parameter int WIDTH         = 32,
    parameter int WINDOW_W      = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int SYNC_CYCLES   = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_a,
    input  logic [WIDTH-1:0]    cmd_b,
    input  logic [WINDOW_W-1:0] cmd_window,
    output logic [WIDTH-1:0]    adder_a,
    output logic [WIDTH-1:0]    adder_b,
    output logic                ring_en,
    output logic                counter_en,
    output logic                counter_clr,
    input  logic [WIDTH-1:0]    counter_value,
    input  logic [WIDTH-1:0]    sum_in,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WIDTH-1:0]    res_count,
    output logic [WIDTH-1:0]    res_sum,
    output logic                res_sum_ok,
    output logic                res_sat,
    output logic                busy
);
    localparam int CNT_W = (WINDOW_W > 16) ? WINDOW_W : 16;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    // SETUP also covers the counter_clr cycle, so it lasts SETTLE_CYCLES + 1 cycles in total.
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SYNC_LD   = CNT_W'(SYNC_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, STOP, CAPTURE, RESULT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WINDOW_W-1:0] win_q;
    logic [WIDTH-1:0]    golden;
    logic                cmd_fire;

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ring_en    = (state_q == RUN);
    assign counter_en = (state_q == RUN);
    assign res_valid  = (state_q == RESULT);
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign golden     = adder_a + adder_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    cnt_d   = SETTLE_LD;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    if (win_q == '0) begin
                        state_d = STOP;
                        cnt_d   = SYNC_LD;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CNT_W'(win_q) - ONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = STOP;
                    cnt_d   = SYNC_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            STOP: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - ONE;
            end
            CAPTURE: state_d = RESULT;
            RESULT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= '0;
            adder_a     <= '0;
            adder_b     <= '0;
            counter_clr <= 1'b0;
            res_count   <= '0;
            res_sum     <= '0;
            res_sum_ok  <= 1'b0;
            res_sat     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            counter_clr <= cmd_fire;
            if (cmd_fire) begin
                adder_a <= cmd_a;
                adder_b <= cmd_b;
                win_q   <= cmd_window;
            end
            // counter_value is quasi-static here: the ring has been off for SYNC_CYCLES.
            if (state_q == CAPTURE) begin
                res_count  <= counter_value;
                res_sum    <= sum_in;
                res_sum_ok <= (sum_in == golden);
                res_sat    <= &counter_value;
            end
        end
    end
endmodule
